// File: rtl/jk_cmd_debouncer.sv
// Two-button debouncer producing one-cycle J/K commands for a downstream jk_ff.
// Each button is synchronized, debounced by a stability counter, and its debounced rising edge issues a pulse.
module jk_cmd_debouncer #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_set,
    input  logic       btn_clr,
    output logic       j,
    output logic       k,
    output logic       set_lvl,
    output logic       clr_lvl,
    output logic [7:0] cmd_cnt
);

    localparam int unsigned CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    // Bit 0 tracks btn_set, bit 1 tracks btn_clr.
    logic [1:0]         meta_q;
    logic [1:0]         sync_q;
    logic [1:0]         lvl_q;
    logic [1:0]         lvl_d;
    logic [1:0]         rise_d;
    logic [1:0][CW-1:0] cnt_q;
    logic [1:0][CW-1:0] cnt_d;
    logic               j_q;
    logic               k_q;
    logic [7:0]         cmd_cnt_q;
    logic [7:0]         cmd_cnt_d;

    always_comb begin
        lvl_d  = lvl_q;
        cnt_d  = '0;
        rise_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    lvl_d[i] = ~lvl_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
            rise_d[i] = lvl_d[i] & ~lvl_q[i];
        end
        // A simultaneous J+K toggle counts as a single command.
        cmd_cnt_d = cmd_cnt_q + 8'(rise_d[0] | rise_d[1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q    <= '0;
            sync_q    <= '0;
            lvl_q     <= '0;
            cnt_q     <= '0;
            j_q       <= 1'b0;
            k_q       <= 1'b0;
            cmd_cnt_q <= 8'h00;
        end else begin
            meta_q    <= {btn_clr, btn_set};
            sync_q    <= meta_q;
            lvl_q     <= lvl_d;
            cnt_q     <= cnt_d;
            j_q       <= rise_d[0];
            k_q       <= rise_d[1];
            cmd_cnt_q <= cmd_cnt_d;
        end
    end

    assign j       = j_q;
    assign k       = k_q;
    assign set_lvl = lvl_q[0];
    assign clr_lvl = lvl_q[1];
    assign cmd_cnt = cmd_cnt_q;

endmodule

// File: tb/tb_jk_cmd_debouncer.sv
// Directed bench for jk_cmd_debouncer: per-edge vector table plus reset and counter-wrap sequences.
module tb_jk_cmd_debouncer;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_set;
    logic       btn_clr;
    logic       j;
    logic       k;
    logic       set_lvl;
    logic       clr_lvl;
    logic [7:0] cmd_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       set;
        logic       clr;
        logic       ej;
        logic       ek;
        logic       esl;
        logic       ecl;
        logic [7:0] ecnt;
    } vec_t;

    vec_t tbl[$];

    jk_cmd_debouncer #(.DB_CYCLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_set (btn_set),
        .btn_clr (btn_clr),
        .j       (j),
        .k       (k),
        .set_lvl (set_lvl),
        .clr_lvl (clr_lvl),
        .cmd_cnt (cmd_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic s, input logic c, input logic ej, input logic ek,
                                input logic esl, input logic ecl, input logic [7:0] ecnt);
        vec_t v;
        v.set = s; v.clr = c; v.ej = ej; v.ek = ek; v.esl = esl; v.ecl = ecl; v.ecnt = ecnt;
        tbl.push_back(v);
    endfunction

    initial begin
        int jcount;

        // Set held from E0: j and set_lvl at E0+5.
        for (int i = 0; i < 8; i++) add(1, 0, i == 5, 0, i >= 5, 0, (i >= 5) ? 8'd1 : 8'd0);
        // Release: level falls 5 edges later, no pulse.
        for (int i = 0; i < 7; i++) add(0, 0, 0, 0, i < 5, 0, 8'd1);
        // 3-cycle glitch is absorbed.
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 8'd1);
        for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 0, 0, 8'd1);
        // Both rise together: single toggle command.
        for (int i = 0; i < 8; i++) add(1, 1, i == 5, i == 5, i >= 5, i >= 5, (i >= 5) ? 8'd2 : 8'd1);
        for (int i = 0; i < 7; i++) add(0, 0, 0, 0, i < 5, i < 5, 8'd2);
        // Bouncing clear, then steady: one k pulse 5 edges after steady begins.
        for (int i = 0; i < 8; i++) add(0, (i % 2) == 0, 0, 0, 0, 0, 8'd2);
        for (int i = 0; i < 8; i++) add(0, 1, 0, i == 5, 0, i >= 5, (i >= 5) ? 8'd3 : 8'd2);
        // Set press while clear held: independent.
        for (int i = 0; i < 8; i++) add(1, 1, i == 5, 0, i >= 5, 1, (i >= 5) ? 8'd4 : 8'd3);
        for (int i = 0; i < 7; i++) add(0, 0, 0, 0, i < 5, i < 5, 8'd4);

        rst = 1'b1; btn_set = 1'b0; btn_clr = 1'b0;
        step();
        step();
        check("rst_j", {7'd0, j}, 8'd0);
        check("rst_k", {7'd0, k}, 8'd0);
        check("rst_cnt", cmd_cnt, 8'd0);
        rst = 1'b0;

        for (int r = 0; r < tbl.size(); r++) begin
            btn_set = tbl[r].set;
            btn_clr = tbl[r].clr;
            step();
            check($sformatf("row%0d_j", r), {7'd0, j}, {7'd0, tbl[r].ej});
            check($sformatf("row%0d_k", r), {7'd0, k}, {7'd0, tbl[r].ek});
            check($sformatf("row%0d_set_lvl", r), {7'd0, set_lvl}, {7'd0, tbl[r].esl});
            check($sformatf("row%0d_clr_lvl", r), {7'd0, clr_lvl}, {7'd0, tbl[r].ecl});
            check($sformatf("row%0d_cnt", r), cmd_cnt, tbl[r].ecnt);
        end

        // Reset mid-count with btn_set held, then fresh pulse after release.
        btn_set = 1'b1; btn_clr = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        #1;
        check("midrst_j", {7'd0, j}, 8'd0);
        check("midrst_k", {7'd0, k}, 8'd0);
        check("midrst_set_lvl", {7'd0, set_lvl}, 8'd0);
        check("midrst_clr_lvl", {7'd0, clr_lvl}, 8'd0);
        check("midrst_cnt", cmd_cnt, 8'd0);
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            check($sformatf("postrst%0d_j", i), {7'd0, j}, {7'd0, i == 5});
            check($sformatf("postrst%0d_set_lvl", i), {7'd0, set_lvl}, {7'd0, i >= 5});
            check($sformatf("postrst%0d_cnt", i), cmd_cnt, (i >= 5) ? 8'd1 : 8'd0);
        end
        btn_set = 1'b0;
        repeat (6) step();
        check("postrst_release", {7'd0, set_lvl}, 8'd0);

        // 255 more presses bring the total to 256: counter wraps to zero.
        for (int p = 2; p <= 256; p++) begin
            jcount = 0;
            btn_set = 1'b1;
            for (int i = 0; i < 7; i++) begin
                step();
                if (j) jcount++;
            end
            btn_set = 1'b0;
            for (int i = 0; i < 7; i++) begin
                step();
                if (j) jcount++;
            end
            check($sformatf("press%0d_pulses", p), 8'(jcount), 8'd1);
            check($sformatf("press%0d_cnt", p), cmd_cnt, 8'(p % 256));
        end
        check("wrap_cnt", cmd_cnt, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
